// File: rtl/fetch_seq_pkg.sv
// ----------------------------------------------------------------------------
// fetch_seq_pkg
//   Shared definitions for the instruction fetch sequencer:
//     - fetch_state_e : binary-encoded sequencer states
//     - PC_SEL_*      : PC_select codes presented to fetch_pipe_unit
//     - NOP_INSN      : bubble instruction (addi x0,x0,0)
// ----------------------------------------------------------------------------
package fetch_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,  // one cycle after reset release
      ST_ISSUE   = 3'd1,  // request driven, waiting for imem_ready
      ST_WAIT    = 3'd2,  // request accepted, waiting for imem_rvalid
      ST_PRESENT = 3'd3,  // instruction presented to decode
      ST_DRAIN   = 3'd4   // flushed while a response is still owed
   } fetch_state_e;

   localparam logic [1:0] PC_SEL_SEQ   = 2'b00;
   localparam logic [1:0] PC_SEL_HOLD  = 2'b01;
   localparam logic [1:0] PC_SEL_FLUSH = 2'b10;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the PC, issues single-outstanding requests to instruction memory and
//   presents instruction + PC to fetch_pipe_unit. Decode stall holds the
//   presented instruction; an execute redirect flushes it and restarts fetch
//   at the new target.
//
// Ports
//   clock             : rising-edge clock
//   reset             : asynchronous active-low reset
//   stall             : decode cannot accept the presented instruction
//   redirect_valid    : taken branch/jump resolved this cycle
//   redirect_target   : new PC (low two bits ignored)
//   imem_req/addr     : request to imem (combinational from state / pc)
//   imem_ready        : request accepted this cycle
//   imem_rvalid/rdata : in-order response, one per accepted request
//   PC_select         : 00 sequential, 01 hold, 10 flush
//   inst_valid_fetch  : presented instruction is real (registered)
//   instruction_fetch : presented instruction, NOP when not valid (registered)
//   inst_PC_fetch     : PC of presented instruction (registered)
// ----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int                        DATA_WIDTH   = 32,
   parameter int                        ADDRESS_BITS = 20,
   parameter logic [ADDRESS_BITS-1:0]   RESET_PC     = '0,
   parameter logic [DATA_WIDTH-1:0]     NOP          = DATA_WIDTH'(NOP_INSN)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    redirect_valid,
   input  logic [ADDRESS_BITS-1:0] redirect_target,
   output logic                    imem_req,
   output logic [ADDRESS_BITS-1:0] imem_addr,
   input  logic                    imem_ready,
   input  logic                    imem_rvalid,
   input  logic [DATA_WIDTH-1:0]   imem_rdata,
   output logic [1:0]              PC_select,
   output logic                    inst_valid_fetch,
   output logic [DATA_WIDTH-1:0]   instruction_fetch,
   output logic [ADDRESS_BITS-1:0] inst_PC_fetch
);

   localparam logic [ADDRESS_BITS-1:0] PC_STEP = ADDRESS_BITS'(4);

   fetch_state_e              state_q, state_d;
   logic [ADDRESS_BITS-1:0]   pc_q, pc_d;
   logic [ADDRESS_BITS-1:0]   req_pc_q, req_pc_d;
   logic                      vld_q, vld_d;
   logic [DATA_WIDTH-1:0]     instr_q, instr_d;
   logic [ADDRESS_BITS-1:0]   ipc_q, ipc_d;

   logic [ADDRESS_BITS-1:0]   tgt_aligned;
   assign tgt_aligned = {redirect_target[ADDRESS_BITS-1:2], 2'b00};

   // -------------------------------------------------------------------------
   // State and output register bank
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         vld_q    <= 1'b0;
         instr_q  <= NOP;
         ipc_q    <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         vld_q    <= vld_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next state / decoded outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      vld_d     = vld_q;
      instr_d   = instr_q;
      ipc_d     = ipc_q;
      imem_req  = (state_q == ST_ISSUE);
      imem_addr = pc_q;
      PC_select = PC_SEL_SEQ;

      if (redirect_valid && (state_q != ST_IDLE)) begin
         // Flush beats stall and any response arriving this cycle. The
         // request in ISSUE is still driven, so an accept here leaves one
         // response owed that must be swallowed in DRAIN.
         PC_select = PC_SEL_FLUSH;
         pc_d      = tgt_aligned;
         vld_d     = 1'b0;
         instr_d   = NOP;
         unique case (state_q)
            ST_ISSUE:   state_d = imem_ready  ? ST_DRAIN : ST_ISSUE;
            ST_WAIT:    state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
            ST_PRESENT: state_d = ST_ISSUE;
            ST_DRAIN:   state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
            default:    state_d = ST_IDLE;
         endcase
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_ISSUE;
            ST_ISSUE: begin
               if (imem_ready) begin
                  req_pc_d = pc_q;
                  state_d  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  vld_d   = 1'b1;
                  instr_d = imem_rdata;
                  ipc_d   = req_pc_q;
                  pc_d    = req_pc_q + PC_STEP;  // wraps modulo 2^ADDRESS_BITS
                  state_d = ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (stall) begin
                  PC_select = PC_SEL_HOLD;
               end else begin
                  vld_d   = 1'b0;
                  instr_d = NOP;
                  state_d = ST_ISSUE;
               end
            end
            ST_DRAIN: begin
               if (imem_rvalid) state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign inst_valid_fetch  = vld_q;
   assign instruction_fetch = instr_q;
   assign inst_PC_fetch     = ipc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   localparam int AW = 20;
   localparam int DW = 32;
   localparam logic [DW-1:0] NOPI = 32'h0000_0013;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          stall = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_target = '0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ready = 1'b0;
   logic          imem_rvalid = 1'b0;
   logic [DW-1:0] imem_rdata = '0;
   logic [1:0]    PC_select;
   logic          inst_valid_fetch;
   logic [DW-1:0] instruction_fetch;
   logic [AW-1:0] inst_PC_fetch;

   fetch_sequencer dut (
      .clock(clock), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .PC_select(PC_select), .inst_valid_fetch(inst_valid_fetch),
      .instruction_fetch(instruction_fetch), .inst_PC_fetch(inst_PC_fetch)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int lat = 1;

   // imem behaviour: in-order responses with a per-request latency
   typedef struct { int due; logic [DW-1:0] data; } resp_t;
   resp_t         memq[$];
   logic [AW-1:0] issued[$];
   logic [AW-1:0] presented[$];
   int            acc_cnt = 0;

   // Reference model: transaction flags, not a state encoding
   bit            m_started, m_issuing, m_inflight, m_owed, m_present;
   logic [AW-1:0] m_pc, m_req_pc, m_ipc;
   logic          m_vld;
   logic [DW-1:0] m_instr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_issuing = 0; m_inflight = 0; m_owed = 0; m_present = 0;
      m_pc = '0; m_req_pc = '0; m_ipc = '0; m_vld = 1'b0; m_instr = NOPI;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(inst_valid_fetch), 32'(0));
      chk({tag, "_instr"}, instruction_fetch, NOPI);
      chk({tag, "_ipc"}, 32'(inst_PC_fetch), 32'(0));
      chk({tag, "_req"}, 32'(imem_req), 32'(0));
      chk({tag, "_sel"}, 32'(PC_select), 32'(0));
   endtask

   // Hold reset low for a few cycles; returns at a negedge with reset released.
   task automatic apply_reset();
      reset = 1'b0;
      stall = 0; redirect_valid = 0; imem_ready = 0; imem_rvalid = 0;
      memq.delete();
      model_reset();
      repeat (3) @(negedge clock);
      chk_reset_vals("reset");
      reset = 1'b1;
   endtask

   // One clock cycle. Entered and left at a negedge.
   task automatic step(input bit st, input bit rdr, input logic [AW-1:0] tgt, input bit rdy);
      bit            rv, acc, any_out;
      logic [DW-1:0] rd;
      logic [1:0]    e_sel;
      int            outstanding;
      chk("valid", 32'(inst_valid_fetch), 32'(m_vld));
      chk("instr", instruction_fetch, m_instr);
      chk("inst_pc", 32'(inst_PC_fetch), 32'(m_ipc));
      if (inst_valid_fetch) presented.push_back(inst_PC_fetch);
      rv = (memq.size() > 0) && (memq[0].due <= cyc);
      rd = rv ? memq[0].data : $urandom;
      stall = st; redirect_valid = rdr; redirect_target = tgt;
      imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
      #1;
      e_sel = (m_started && rdr) ? 2'b10 : ((m_present && st) ? 2'b01 : 2'b00);
      chk("imem_req", 32'(imem_req), 32'(m_issuing));
      if (m_issuing) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("pc_select", 32'(PC_select), 32'(e_sel));
      acc = imem_req && rdy;
      if (rv) void'(memq.pop_front());
      if (acc) begin
         memq.push_back('{due: cyc + lat, data: $urandom});
         issued.push_back(imem_addr);
         acc_cnt++;
      end
      @(posedge clock);
      any_out = m_inflight || m_owed;
      if (!m_started) begin
         m_started = 1; m_issuing = 1;
      end else if (rdr) begin
         outstanding = int'(any_out) + int'(m_issuing && rdy) - int'(rv && any_out);
         m_owed = (outstanding > 0);
         m_issuing = !m_owed;
         m_inflight = 0; m_present = 0;
         m_pc = {tgt[AW-1:2], 2'b00};
         m_vld = 1'b0; m_instr = NOPI;
      end else if (m_issuing && rdy) begin
         m_req_pc = m_pc; m_inflight = 1; m_issuing = 0;
      end else if (m_inflight && rv) begin
         m_vld = 1'b1; m_instr = rd; m_ipc = m_req_pc;
         m_pc = m_req_pc + AW'(4);
         m_inflight = 0; m_present = 1;
      end else if (m_owed && rv) begin
         m_owed = 0; m_issuing = 1;
      end else if (m_present && !st) begin
         m_vld = 1'b0; m_instr = NOPI; m_present = 0; m_issuing = 1;
      end
      cyc++;
      @(negedge clock);
   endtask

   initial begin
      int a0;
      model_reset();
      @(negedge clock);
      apply_reset();

      // Sequential fetch, ready always, response one cycle after accept
      lat = 1;
      issued.delete(); presented.delete();
      repeat (14) step(0, 0, '0, 1);
      chk("seq_issued_n", 32'(issued.size() >= 3), 32'(1));
      chk("seq_presented_n", 32'(presented.size() >= 3), 32'(1));
      if (issued.size() >= 3) begin
         chk("seq_addr0", 32'(issued[0]), 32'h0);
         chk("seq_addr1", 32'(issued[1]), 32'h4);
         chk("seq_addr2", 32'(issued[2]), 32'h8);
      end
      if (presented.size() >= 3) begin
         chk("seq_pc0", 32'(presented[0]), 32'h0);
         chk("seq_pc1", 32'(presented[presented.size()-1] >= 20'h8), 32'(1));
      end

      // Stall held three cycles while presenting: no new requests
      for (int i = 0; i < 20 && !m_present; i++) step(0, 0, '0, 1);
      chk("reach_present", 32'(m_present), 32'(1));
      a0 = acc_cnt;
      repeat (3) step(1, 0, '0, 1);
      chk("stall_no_req", 32'(acc_cnt - a0), 32'(0));
      step(0, 0, '0, 1);

      // Redirect while waiting, response arrives the next cycle and is dropped
      lat = 2;
      for (int i = 0; i < 20 && !m_inflight; i++) step(0, 0, '0, 1);
      chk("reach_wait", 32'(m_inflight), 32'(1));
      issued.delete(); presented.delete();
      step(0, 1, 20'h00104, 1);
      repeat (8) step(0, 0, '0, 1);
      chk("rdr_issued_n", 32'(issued.size() > 0), 32'(1));
      if (issued.size() > 0) chk("rdr_addr", 32'(issued[0]), 32'h104);
      chk("rdr_pc_first", 32'(presented.size() > 0 ? presented[0] : 20'h104), 32'h104);

      // Redirect together with stall while presenting: flush wins
      lat = 1;
      for (int i = 0; i < 20 && !m_present; i++) step(0, 0, '0, 1);
      chk("reach_present2", 32'(m_present), 32'(1));
      issued.delete();
      step(1, 1, 20'h00203, 1);
      chk("flush_valid", 32'(inst_valid_fetch), 32'(0));
      chk("flush_instr", instruction_fetch, NOPI);
      step(0, 0, '0, 1);
      chk("flush_issued_n", 32'(issued.size()), 32'(1));
      if (issued.size() > 0) chk("flush_addr", 32'(issued[0]), 32'h200);

      // PC wrap at the top of the address space
      for (int i = 0; i < 20 && !m_present; i++) step(0, 0, '0, 1);
      step(0, 1, 20'hFFFFE, 1);
      issued.delete();
      repeat (12) step(0, 0, '0, 1);
      chk("wrap_issued_n", 32'(issued.size() >= 2), 32'(1));
      if (issued.size() >= 2) begin
         chk("wrap_addr_top", 32'(issued[0]), 32'hFFFFC);
         chk("wrap_addr_zero", 32'(issued[1]), 32'h0);
      end

      // Asynchronous reset while waiting for a response
      lat = 3;
      for (int i = 0; i < 20 && !m_inflight; i++) step(0, 0, '0, 1);
      chk("reach_wait2", 32'(m_inflight), 32'(1));
      for (int i = 0; i < 20 && !m_present; i++) step(0, 0, '0, 1);
      for (int i = 0; i < 20 && !m_inflight; i++) step(0, 0, '0, 1);
      #2 reset = 1'b0;
      #1 chk_reset_vals("async");
      @(negedge clock);
      apply_reset();
      issued.delete();
      repeat (4) step(0, 0, '0, 1);
      chk("restart_issued_n", 32'(issued.size() > 0), 32'(1));
      if (issued.size() > 0) chk("restart_addr", 32'(issued[0]), 32'h0);

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [AW-1:0] t;
         lat = int'($urandom_range(1, 3));
         t = ($urandom_range(0, 7) == 0) ? AW'(20'hFFFF0 + $urandom_range(0, 15))
                                        : AW'($urandom);
         step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, t,
              $urandom_range(0, 9) < 6);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
